mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Single-cycle arbiter sharing the one byte-wide memory between the multicycle CPU controller's memory port and a DMA/loader port. CPU has default priority; a starvation counter hands priority to DMA for a bounded burst, then returns it. A denied CPU access raises `cpu_stall`, which holds the controller's state register and `pcen`. DMA read data is registered and returned one cycle after grant.

## Interface
- `WIDTH`, 8, data width in bits
- `AWIDTH`, 8, address width in bits
- `STARVE_MAX`, 8, consecutive denied DMA request cycles before priority flips to DMA (legal 1..15)
- `BURST`, 4, maximum DMA grants per DMA-priority window (legal 1..15)

- `clk`  in  1  clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `cpu_memread`  in  1  CPU read request (MemRead)
- `cpu_memwrite`  in  1  CPU write request (MemWrite)
- `cpu_adr`  in  AWIDTH  CPU address
- `cpu_wd`  in  WIDTH  CPU write data
- `cpu_rd`  out  WIDTH  read data to CPU (combinational from `mem_rd`)
- `cpu_stall`  out  1  CPU access requested but not granted this cycle
- `dma_req`  in  1  DMA access request, held until granted
- `dma_we`  in  1  1 = write, 0 = read
- `dma_adr`  in  AWIDTH  DMA address
- `dma_wd`  in  WIDTH  DMA write data
- `dma_gnt`  out  1  DMA access performed this cycle
- `dma_rvalid`  out  1  registered; `dma_rdata` valid
- `dma_rdata`  out  WIDTH  registered DMA read data
- `mem_re`  out  1  memory read enable
- `mem_we`  out  1  memory write enable (memory writes on rising edge)
- `mem_adr`  out  AWIDTH  memory address
- `mem_wd`  out  WIDTH  memory write data
- `mem_rd`  in  WIDTH  memory read data (combinational, same cycle)

## Operation
- `cpu_acc` = `cpu_memread` | `cpu_memwrite`. `cpu_memread` and `cpu_memwrite` both high is illegal; treat the access as a write.
- Priority FSM, 2 states:
  - CPU_PRI: on conflict the CPU wins.
  - DMA_PRI: on conflict DMA wins.
- Grant, combinational:
  - One requester only: grant it.
  - Both requesting: grant the priority owner.
  - Neither requesting: no grant, `mem_re` = `mem_we` = 0.
- Memory mux:
  - CPU granted: `mem_adr`=`cpu_adr`, `mem_wd`=`cpu_wd`, `mem_re`=`cpu_memread`, `mem_we`=`cpu_memwrite`.
  - DMA granted: `mem_adr`=`dma_adr`, `mem_wd`=`dma_wd`, `mem_re`=!`dma_we`, `mem_we`=`dma_we`.
  - No grant: address and data = 0.
- `cpu_rd` = `mem_rd` at all times. `cpu_stall` = `cpu_acc` & !CPU-granted.
- `starve_cnt` (4 bit), updated in CPU_PRI:
  - `dma_req` & !`dma_gnt`: increment.
  - `dma_gnt`: clear.
  - !`dma_req`: clear.
  - Increment that reaches `STARVE_MAX`: next state DMA_PRI, clear `starve_cnt` and `burst_cnt`.
- `burst_cnt` (4 bit), updated in DMA_PRI:
  - Increments on each `dma_gnt`.
  - Grant that brings it to `BURST`: next state CPU_PRI, clear `burst_cnt`.
  - `dma_req` low in DMA_PRI: next state CPU_PRI immediately, clear `burst_cnt`.
- DMA read return: if `dma_gnt` & !`dma_we`, next cycle `dma_rvalid`=1 and `dma_rdata`=`mem_rd` captured at the grant edge. Otherwise `dma_rvalid`=0 and `dma_rdata` holds its value.

## Timing
- Reset (synchronous), values after the edge: state CPU_PRI, `starve_cnt`=0, `burst_cnt`=0, `dma_rvalid`=0, `dma_rdata`=0.
- While `reset` is high, combinational outputs are forced: `mem_we`=0, `mem_re`=0, `dma_gnt`=0, `cpu_stall`=0.
- Reset during a DMA_PRI burst drops the burst, and no `dma_rvalid` follows.
- Grant decision is same-cycle, with zero added latency to CPU accesses. The 4-cycle FETCH and LBRD/SBWR states are unaffected when DMA is idle.
- DMA read latency: 1 cycle from `dma_gnt` to `dma_rvalid`. DMA write commits at the grant edge.
- Handshake: DMA holds `req`, `we`, `adr` and `wd` stable until the cycle `dma_gnt`=1. It may drop `req` or present a new request the next cycle, giving back-to-back grants at 1 per cycle.
- Worst-case DMA wait under continuous CPU traffic: `STARVE_MAX` cycles. Worst-case CPU stall: `BURST` consecutive cycles.
- Flip to DMA_PRI takes effect the cycle after `starve_cnt` reaches `STARVE_MAX`. The return to CPU_PRI takes effect the cycle after the `BURST`-th grant.

## Test plan
- Reset with both requesters active → `mem_we`=0, `dma_gnt`=0, `cpu_stall`=0. The first cycle after reset grants the CPU.
- CPU-only, `cpu_memread` at `cpu_adr`=0x10, `mem_rd`=0xA5 → `mem_re`=1, `mem_adr`=0x10, `cpu_rd`=0xA5 the same cycle, `cpu_stall`=0.
- DMA-only write 0x3C to 0x80, then read of 0x80 → `dma_gnt` in 2 consecutive cycles. `dma_rvalid`=1 with `dma_rdata`=0x3C one cycle after the read grant.
- Continuous CPU and DMA requests with defaults → CPU granted 8 cycles, DMA granted next 4 cycles with `cpu_stall`=1, then CPU again. The pattern repeats with period 12.
- DMA in DMA_PRI drops `req` after 2 grants → CPU granted the next cycle, state CPU_PRI, and `starve_cnt` restarts from 0.
- `reset` asserted on the 2nd grant of a DMA burst → the next cycle has `dma_rvalid`=0, state CPU_PRI, and the CPU is granted.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shares one byte-wide memory between the CPU controller port and a DMA/loader port.
// The CPU wins by default; a starved DMA gets a bounded burst of priority.
module mem_arbiter #(
    parameter int WIDTH      = 8,
    parameter int AWIDTH     = 8,
    parameter int STARVE_MAX = 8,
    parameter int BURST      = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_memread,
    input  logic              cpu_memwrite,
    input  logic [AWIDTH-1:0] cpu_adr,
    input  logic [WIDTH-1:0]  cpu_wd,
    output logic [WIDTH-1:0]  cpu_rd,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [AWIDTH-1:0] dma_adr,
    input  logic [WIDTH-1:0]  dma_wd,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [WIDTH-1:0]  dma_rdata,
    output logic              mem_re,
    output logic              mem_we,
    output logic [AWIDTH-1:0] mem_adr,
    output logic [WIDTH-1:0]  mem_wd,
    input  logic [WIDTH-1:0]  mem_rd
);
    localparam logic [0:0] CPU_PRI = 1'b0;
    localparam logic [0:0] DMA_PRI = 1'b1;
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [3:0] BURST_LIM  = 4'(BURST);

    logic [0:0]       state_q, state_d;
    logic [3:0]       starve_q, starve_d;
    logic [3:0]       burst_q, burst_d;
    logic             rvalid_q, rvalid_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             cpu_acc, cpu_gnt;

    always_comb begin
        cpu_acc = cpu_memread | cpu_memwrite;
        cpu_gnt = !reset && cpu_acc && (!dma_req || state_q == CPU_PRI);
        dma_gnt = !reset && dma_req && (!cpu_acc || state_q == DMA_PRI);
        cpu_stall = !reset && cpu_acc && !cpu_gnt;
        cpu_rd  = mem_rd;
        mem_re  = 1'b0;
        mem_we  = 1'b0;
        mem_adr = '0;
        mem_wd  = '0;
        if (cpu_gnt) begin
            // Both strobes high is illegal; it resolves to a write.
            mem_re  = cpu_memread && !cpu_memwrite;
            mem_we  = cpu_memwrite;
            mem_adr = cpu_adr;
            mem_wd  = cpu_wd;
        end else if (dma_gnt) begin
            mem_re  = !dma_we;
            mem_we  = dma_we;
            mem_adr = dma_adr;
            mem_wd  = dma_wd;
        end
    end

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        burst_d  = burst_q;
        rvalid_d = dma_gnt && !dma_we;
        rdata_d  = (dma_gnt && !dma_we) ? mem_rd : rdata_q;
        if (state_q == CPU_PRI) begin
            if (dma_req && !dma_gnt) begin
                starve_d = starve_q + 4'd1;
                if (starve_d == STARVE_LIM) begin
                    state_d  = DMA_PRI;
                    starve_d = '0;
                    burst_d  = '0;
                end
            end else begin
                starve_d = '0;
            end
        end else begin
            // An abandoned request ends the window early.
            if (!dma_req) begin
                state_d = CPU_PRI;
                burst_d = '0;
            end else if (dma_gnt) begin
                burst_d = burst_q + 4'd1;
                if (burst_d == BURST_LIM) begin
                    state_d = CPU_PRI;
                    burst_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= CPU_PRI;
            starve_q <= '0;
            burst_q  <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            burst_q  <= burst_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign dma_rvalid = rvalid_q;
    assign dma_rdata  = rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter against a behavioural model
// of who owns the memory each cycle, plus a byte-array memory.
module tb_mem_arbiter;
    localparam int STARVE_MAX = 8;
    localparam int BURST      = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cpu_memread = 1'b0, cpu_memwrite = 1'b0;
    logic [7:0] cpu_adr = '0, cpu_wd = '0, cpu_rd;
    logic       cpu_stall;
    logic       dma_req = 1'b0, dma_we = 1'b0;
    logic [7:0] dma_adr = '0, dma_wd = '0;
    logic       dma_gnt, dma_rvalid;
    logic [7:0] dma_rdata;
    logic       mem_re, mem_we;
    logic [7:0] mem_adr, mem_wd, mem_rd;

    logic [7:0] mem [256];
    assign mem_rd = mem[mem_adr];

    mem_arbiter #(.WIDTH(8), .AWIDTH(8), .STARVE_MAX(STARVE_MAX), .BURST(BURST)) dut (
        .clk(clk), .reset(reset),
        .cpu_memread(cpu_memread), .cpu_memwrite(cpu_memwrite), .cpu_adr(cpu_adr),
        .cpu_wd(cpu_wd), .cpu_rd(cpu_rd), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_adr(dma_adr), .dma_wd(dma_wd),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_re(mem_re), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wd(mem_wd),
        .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: dma_owns says DMA currently wins conflicts; wait_streak counts
    // consecutive denied DMA cycles; window_grants counts grants while DMA owns.
    bit         dma_owns = 0;
    int         wait_streak = 0;
    int         window_grants = 0;
    bit         m_rvalid = 0;
    logic [7:0] m_rdata = '0;
    bit         prev_gnt = 0;
    bit         mem_init = 0;
    bit         chk_en = 0;

    function automatic bit cpu_wants();
        return cpu_memread || cpu_memwrite;
    endfunction
    function automatic bit exp_cpu_g();
        return !reset && cpu_wants() && (!dma_req || !dma_owns);
    endfunction
    function automatic bit exp_dma_g();
        return !reset && dma_req && (!cpu_wants() || dma_owns);
    endfunction

    always @(posedge clk) begin
        bit gc, gd;
        if (reset) begin
            if (!mem_init) begin
                for (int i = 0; i < 256; i++) mem[i] = 8'h00;
                mem_init = 1;
            end
            dma_owns = 0; wait_streak = 0; window_grants = 0;
            m_rvalid = 0; m_rdata = '0; prev_gnt = 0;
        end else begin
            gc = exp_cpu_g();
            gd = exp_dma_g();
            m_rvalid = gd && !dma_we;
            if (m_rvalid) m_rdata = mem[dma_adr];
            if (gc && cpu_memwrite) mem[cpu_adr] = cpu_wd;
            if (gd && dma_we) mem[dma_adr] = dma_wd;
            if (!dma_owns) begin
                wait_streak = (dma_req && !gd) ? wait_streak + 1 : 0;
                if (wait_streak == STARVE_MAX) begin
                    dma_owns = 1; wait_streak = 0; window_grants = 0;
                end
            end else if (!dma_req) begin
                dma_owns = 0; window_grants = 0;
            end else if (gd) begin
                window_grants++;
                if (window_grants == BURST) begin
                    dma_owns = 0; window_grants = 0;
                end
            end
            prev_gnt = gd;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            bit gc, gd;
            logic [7:0] ea;
            gc = exp_cpu_g();
            gd = exp_dma_g();
            ea = gc ? cpu_adr : (gd ? dma_adr : 8'h00);
            chk("dma_gnt", 32'(dma_gnt), 32'(gd));
            chk("cpu_stall", 32'(cpu_stall), 32'(!reset && cpu_wants() && !gc));
            chk("mem_adr", 32'(mem_adr), 32'(ea));
            chk("mem_wd", 32'(mem_wd), 32'(gc ? cpu_wd : (gd ? dma_wd : 8'h00)));
            chk("mem_re", 32'(mem_re), 32'(gc ? (cpu_memread && !cpu_memwrite) : (gd && !dma_we)));
            chk("mem_we", 32'(mem_we), 32'(gc ? cpu_memwrite : (gd && dma_we)));
            chk("cpu_rd", 32'(cpu_rd), 32'(mem[ea]));
            chk("dma_rvalid", 32'(dma_rvalid), 32'(m_rvalid));
            chk("dma_rdata", 32'(dma_rdata), 32'(m_rdata));
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic idle_inputs();
        cpu_memread = 0; cpu_memwrite = 0; dma_req = 0; dma_we = 0;
    endtask

    task automatic do_reset();
        reset = 1; idle_inputs();
        cyc(); cyc();
        reset = 0;
    endtask

    initial begin
        cyc(); cyc();
        chk_en = 1;

        // Reset with both requesters active, then first free cycle goes to the CPU.
        reset = 1; cpu_memwrite = 1; cpu_adr = 8'h22; cpu_wd = 8'h11;
        dma_req = 1; dma_we = 1; dma_adr = 8'h33; dma_wd = 8'h44;
        @(negedge clk);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_dma_gnt", 32'(dma_gnt), 0);
        chk("rst_cpu_stall", 32'(cpu_stall), 0);
        cyc(); cyc();
        reset = 0;
        @(negedge clk);
        chk("post_rst_cpu_gnt", 32'(mem_adr), 32'h22);
        chk("post_rst_dma_gnt", 32'(dma_gnt), 0);
        chk("post_rst_dma_rvalid", 32'(dma_rvalid), 0);

        // CPU-only write then read of 0x10.
        do_reset();
        cpu_memwrite = 1; cpu_adr = 8'h10; cpu_wd = 8'hA5;
        cyc();
        cpu_memwrite = 0; cpu_memread = 1;
        @(negedge clk);
        chk("cpu_rd_re", 32'(mem_re), 1);
        chk("cpu_rd_adr", 32'(mem_adr), 32'h10);
        chk("cpu_rd_data", 32'(cpu_rd), 32'hA5);
        chk("cpu_rd_stall", 32'(cpu_stall), 0);

        // DMA-only write then read of 0x80.
        do_reset();
        dma_req = 1; dma_we = 1; dma_adr = 8'h80; dma_wd = 8'h3C;
        @(negedge clk);
        chk("dma_wr_gnt", 32'(dma_gnt), 1);
        cyc();
        dma_we = 0;
        @(negedge clk);
        chk("dma_rd_gnt", 32'(dma_gnt), 1);
        cyc();
        dma_req = 0;
        @(negedge clk);
        chk("dma_rvalid", 32'(dma_rvalid), 1);
        chk("dma_rdata", 32'(dma_rdata), 32'h3C);

        // Continuous contention: 8 CPU cycles, 4 DMA cycles, period 12.
        do_reset();
        cpu_memread = 1; cpu_adr = 8'h01; dma_req = 1; dma_we = 0; dma_adr = 8'h02;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            chk("pat_dma_gnt", 32'(dma_gnt), 32'((i % 12) >= 8));
            chk("pat_cpu_stall", 32'(cpu_stall), 32'((i % 12) >= 8));
            cyc();
        end

        // DMA drops req after 2 grants of its window.
        do_reset();
        cpu_memread = 1; dma_req = 1;
        for (int i = 0; i < 10; i++) cyc();
        dma_req = 0;
        @(negedge clk);
        chk("drop_cpu_stall", 32'(cpu_stall), 0);
        chk("drop_mem_adr", 32'(mem_adr), 32'h01);
        cyc();
        dma_req = 1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk("drop_restart_gnt", 32'(dma_gnt), 32'(i == 8));
            cyc();
        end

        // Reset on the 2nd grant of a burst.
        do_reset();
        cpu_memread = 1; dma_req = 1;
        for (int i = 0; i < 9; i++) cyc();
        reset = 1;
        cyc();
        reset = 0;
        @(negedge clk);
        chk("brst_rst_rvalid", 32'(dma_rvalid), 0);
        chk("brst_rst_dma_gnt", 32'(dma_gnt), 0);
        chk("brst_rst_cpu_stall", 32'(cpu_stall), 0);

        // Randomized traffic; DMA holds its request until granted.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 99) == 0);
            case ($urandom_range(0, 9))
                0, 1, 2: begin cpu_memread = 0; cpu_memwrite = 0; end
                3, 4, 5: begin cpu_memread = 1; cpu_memwrite = 0; end
                6, 7, 8: begin cpu_memread = 0; cpu_memwrite = 1; end
                default: begin cpu_memread = 1; cpu_memwrite = 1; end
            endcase
            cpu_adr = 8'($urandom_range(0, 15));
            cpu_wd  = 8'($urandom);
            if (!dma_req || prev_gnt) begin
                dma_req = ($urandom_range(0, 3) != 0);
                dma_we  = 1'($urandom);
                dma_adr = 8'($urandom_range(0, 15));
                dma_wd  = 8'($urandom);
            end
            cyc();
        end

        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
